// File: rtl/mips_muldiv_unit.sv
// ---------------------------------------------------------------------------
// mips_muldiv_unit
//
// Multi-cycle MULT/MULTU/DIV/DIVU engine that owns the architectural HI/LO
// registers. Operands arrive from the register file (rs -> op_a_i,
// rt -> op_b_i). hi_o/lo_o are plain registers that feed the MFHI/MFLO
// path combinationally. The control unit must stall while busy_o is high.
//
// An accepted mul/div spends WIDTH cycles iterating, one bit per cycle, and
// then one fix-up cycle that applies signs and writes HI/LO. MTHI/MTLO
// write their register on the next edge without occupying the engine.
//
// Ports
//   clk_i          rising-edge clock
//   rst_ni         synchronous reset, active low; aborts any operation
//   start_i        request, sampled at posedge (ignored while busy)
//   op_i           0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 NOP
//   op_a_i         rs: multiplicand / dividend / MTHI-MTLO data
//   op_b_i         rt: multiplier / divisor
//   busy_o         engine running
//   done_o         one-cycle pulse when HI/LO are written by a mul/div
//   div_by_zero_o  sticky flag, set by DIV/DIVU with a zero divisor
//   hi_o, lo_o     HI and LO registers
// ---------------------------------------------------------------------------
module mips_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] op_a_i,
   input  logic [WIDTH-1:0] op_b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             div_by_zero_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic [CW-1:0]    count_q, count_d;
   // Shared working pair: multiply keeps {upper partial product, multiplier
   // shifting out}; divide keeps {partial remainder, dividend shifting out /
   // quotient shifting in}.
   logic [WIDTH-1:0] accHi_q, accHi_d;
   logic [WIDTH-1:0] accLo_q, accLo_d;
   // Multiplicand magnitude for multiply, divisor magnitude for divide.
   logic [WIDTH-1:0] operand_q, operand_d;
   logic [WIDTH-1:0] rawA_q, rawA_d;
   logic             isDiv_q, isDiv_d;
   logic             negRes_q, negRes_d;
   logic             negRem_q, negRem_d;
   logic             divZero_q, divZero_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             dbz_q, dbz_d;
   logic             done_q, done_d;

   // Operand sign handling at acceptance: only MULT and DIV are signed.
   logic             signedOp;
   logic             negA, negB;
   logic [WIDTH-1:0] magA, magB;

   assign signedOp = (op_i == OP_MULT) || (op_i == OP_DIV);
   assign negA     = signedOp & op_a_i[WIDTH-1];
   assign negB     = signedOp & op_b_i[WIDTH-1];
   assign magA     = negA ? -op_a_i : op_a_i;
   assign magB     = negB ? -op_b_i : op_b_i;

   // Shift-add step: add the multiplicand when the current multiplier bit is
   // set, then shift the whole 2*WIDTH pair right by one. The carry bit of
   // the sum becomes the new top bit.
   logic [WIDTH-1:0] addend;
   logic [WIDTH:0]   mulSum;

   assign addend = accLo_q[0] ? operand_q : '0;
   assign mulSum = {1'b0, accHi_q} + {1'b0, addend};

   // Restoring division step: shift the next dividend bit into the partial
   // remainder and try subtracting the divisor. If the shifted value already
   // overflowed WIDTH bits it is certainly >= divisor; otherwise the top bit
   // of the trial difference is the borrow.
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;
   logic           fits;

   assign shifted = {accHi_q, accLo_q[WIDTH-1]};
   assign trial   = shifted - {1'b0, operand_q};
   assign fits    = shifted[WIDTH] | ~trial[WIDTH];

   // Final sign application for the fix-up cycle.
   logic [2*WIDTH-1:0] product;
   logic [2*WIDTH-1:0] signedProduct;
   logic [WIDTH-1:0]   signedQuot;
   logic [WIDTH-1:0]   signedRem;

   assign product       = {accHi_q, accLo_q};
   assign signedProduct = negRes_q ? -product : product;
   assign signedQuot    = negRes_q ? -accLo_q : accLo_q;
   assign signedRem     = negRem_q ? -accHi_q : accHi_q;

   // Next-state and datapath logic. Everything holds by default; IDLE accepts
   // requests, RUN iterates one bit per cycle, FIX writes HI/LO and pulses
   // done. A zero divisor lets the iterations run so latency is unchanged,
   // but their result is discarded in FIX.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      accHi_d   = accHi_q;
      accLo_d   = accLo_q;
      operand_d = operand_q;
      rawA_d    = rawA_q;
      isDiv_d   = isDiv_q;
      negRes_d  = negRes_q;
      negRem_d  = negRem_q;
      divZero_d = divZero_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      dbz_d     = dbz_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               case (op_i)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     isDiv_d   = op_i[1];
                     accHi_d   = '0;
                     accLo_d   = op_i[1] ? magA : magB;
                     operand_d = op_i[1] ? magB : magA;
                     rawA_d    = op_a_i;
                     negRes_d  = negA ^ negB;
                     negRem_d  = negA;
                     divZero_d = (op_b_i == '0);
                     count_d   = '0;
                     state_d   = RUN;
                  end
                  OP_MTHI: hi_d = op_a_i;
                  OP_MTLO: lo_d = op_a_i;
                  default: ;
               endcase
            end
         end

         RUN: begin
            if (isDiv_q) begin
               accHi_d = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
               accLo_d = {accLo_q[WIDTH-2:0], fits};
            end else begin
               accHi_d = mulSum[WIDTH:1];
               accLo_d = {mulSum[0], accLo_q[WIDTH-1:1]};
            end
            count_d = count_q + CW'(1);
            if (count_q == LAST_COUNT) begin
               state_d = FIX;
            end
         end

         FIX: begin
            if (!isDiv_q) begin
               hi_d = signedProduct[2*WIDTH-1:WIDTH];
               lo_d = signedProduct[WIDTH-1:0];
            end else if (divZero_q) begin
               hi_d  = rawA_q;
               lo_d  = '1;
               dbz_d = 1'b1;
            end else begin
               hi_d = signedRem;
               lo_d = signedQuot;
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // State register; reset returns to IDLE and abandons any operation.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and architectural registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q   <= '0;
         accHi_q   <= '0;
         accLo_q   <= '0;
         operand_q <= '0;
         rawA_q    <= '0;
         isDiv_q   <= 1'b0;
         negRes_q  <= 1'b0;
         negRem_q  <= 1'b0;
         divZero_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         dbz_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         count_q   <= count_d;
         accHi_q   <= accHi_d;
         accLo_q   <= accLo_d;
         operand_q <= operand_d;
         rawA_q    <= rawA_d;
         isDiv_q   <= isDiv_d;
         negRes_q  <= negRes_d;
         negRem_q  <= negRem_d;
         divZero_q <= divZero_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         dbz_q     <= dbz_d;
         done_q    <= done_d;
      end
   end

   assign busy_o        = (state_q != IDLE);
   assign done_o        = done_q;
   assign div_by_zero_o = dbz_q;
   assign hi_o          = hi_q;
   assign lo_o          = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_mips_muldiv_unit
//
// Directed bench for mips_muldiv_unit. A transaction-level model computes
// HI/LO results with ordinary 64-bit and signed integer arithmetic and
// tracks only "how many cycles until the result lands"; a compare process
// checks every DUT output against it on every falling edge. Hand-computed
// literal values after each operation pin the model itself.
// ---------------------------------------------------------------------------
module tb_mips_muldiv_unit;

   localparam int WIDTH   = 32;
   localparam int LATENCY = WIDTH + 1;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] opA;
   logic [31:0] opB;
   logic        busy;
   logic        done;
   logic        dbz;
   logic [31:0] hi;
   logic [31:0] lo;

   int compared = 0;
   int failed   = 0;
   bit checking = 0;

   mips_muldiv_unit #(.WIDTH(WIDTH)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .start_i       (start),
      .op_i          (op),
      .op_a_i        (opA),
      .op_b_i        (opB),
      .busy_o        (busy),
      .done_o        (done),
      .div_by_zero_o (dbz),
      .hi_o          (hi),
      .lo_o          (lo)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Absolute safety net in case something upstream never returns.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } result_t;

   // Architectural result of a mul/div, straight from the ISA definition.
   function automatic result_t computeResult(input logic [2:0] o,
                                             input logic [31:0] x,
                                             input logic [31:0] y);
      result_t          r;
      longint           p;
      longint unsigned  pu;
      int               q;
      int               rm;
      r = '0;
      case (o)
         3'd0: begin
            p    = longint'($signed(x)) * longint'($signed(y));
            r.hi = p[63:32];
            r.lo = p[31:0];
         end
         3'd1: begin
            pu   = {32'b0, x} * {32'b0, y};
            r.hi = pu[63:32];
            r.lo = pu[31:0];
         end
         3'd2: begin
            if (y == 32'd0) begin
               r.hi  = x;
               r.lo  = 32'hFFFF_FFFF;
               r.dbz = 1'b1;
            end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
               r.hi = 32'd0;
               r.lo = 32'h8000_0000;
            end else begin
               q    = $signed(x) / $signed(y);
               rm   = $signed(x) % $signed(y);
               r.lo = q;
               r.hi = rm;
            end
         end
         default: begin
            if (y == 32'd0) begin
               r.hi  = x;
               r.lo  = 32'hFFFF_FFFF;
               r.dbz = 1'b1;
            end else begin
               r.lo = x / y;
               r.hi = x % y;
            end
         end
      endcase
      return r;
   endfunction

   // Model state: expected architectural registers plus a countdown to the
   // moment a pending mul/div result becomes visible.
   logic [31:0] mHi   = '0;
   logic [31:0] mLo   = '0;
   bit          mDbz  = 0;
   bit          mDone = 0;
   int          mLeft = 0;
   result_t     mPend = '0;

   // Model update on each rising edge, using the inputs as sampled there.
   always @(posedge clk) begin
      mDone <= 1'b0;
      if (!rst_n) begin
         mHi   <= '0;
         mLo   <= '0;
         mDbz  <= 1'b0;
         mLeft <= 0;
      end else if (mLeft > 0) begin
         mLeft <= mLeft - 1;
         if (mLeft == 1) begin
            mHi   <= mPend.hi;
            mLo   <= mPend.lo;
            mDone <= 1'b1;
            if (mPend.dbz) mDbz <= 1'b1;
         end
      end else if (start) begin
         if (op <= 3'd3) begin
            mPend <= computeResult(op, opA, opB);
            mLeft <= LATENCY;
         end else if (op == 3'd4) begin
            mHi <= opA;
         end else if (op == 3'd5) begin
            mLo <= opA;
         end
      end
   end

   // One comparison with its pass/fail bookkeeping.
   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Continuous comparison of every output against the model.
   always @(negedge clk) begin
      if (checking) begin
         checkOutput("model_busy", 32'(busy), 32'(mLeft > 0));
         checkOutput("model_done", 32'(done), 32'(mDone));
         checkOutput("model_dbz",  32'(dbz),  32'(mDbz));
         checkOutput("model_hi",   hi, mHi);
         checkOutput("model_lo",   lo, mLo);
      end
   end

   // Present one request for a single rising edge; called at a falling edge.
   task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x,
                                input logic [31:0] y);
      start = 1'b1;
      op    = o;
      opA   = x;
      opB   = y;
      @(negedge clk);
      start = 1'b0;
      op    = 3'd6;
   endtask

   // Wait (bounded) for the done pulse, counting busy cycles on the way.
   task automatic waitDone(output int busyCycles);
      int n;
      bit sawDone;
      n = 0;
      sawDone = 0;
      busyCycles = 0;
      while (!sawDone && n < 60) begin
         if (busy) busyCycles++;
         @(negedge clk);
         n++;
         if (done) sawDone = 1;
      end
      checkOutput("done_seen", 32'(sawDone), 32'd1);
   endtask

   // After a done pulse, the following cycle must have done low again.
   task automatic checkSinglePulse();
      @(negedge clk);
      checkOutput("done_single", 32'(done), 32'd0);
   endtask

   int cycles;

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      op    = 3'd6;
      opA   = '0;
      opB   = '0;
      repeat (2) @(negedge clk);
      checking = 1;
      checkOutput("reset_hi",   hi, 32'd0);
      checkOutput("reset_lo",   lo, 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_dbz",  32'(dbz), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // T1: MULTU of two all-ones operands.
      applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      waitDone(cycles);
      checkOutput("t1_busy_cycles", 32'(cycles), 32'd33);
      checkOutput("t1_hi", hi, 32'hFFFF_FFFE);
      checkOutput("t1_lo", lo, 32'h0000_0001);
      checkSinglePulse();

      // T2: MULT -3 * 7 = -21.
      applyStimulus(3'd0, 32'hFFFF_FFFD, 32'd7);
      waitDone(cycles);
      checkOutput("t2_busy_cycles", 32'(cycles), 32'd33);
      checkOutput("t2_hi", hi, 32'hFFFF_FFFF);
      checkOutput("t2_lo", lo, 32'hFFFF_FFEB);
      checkSinglePulse();

      // T3: DIV -7 / 2 and DIVU 100 / 7.
      applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2);
      waitDone(cycles);
      checkOutput("t3_div_lo", lo, 32'hFFFF_FFFD);
      checkOutput("t3_div_hi", hi, 32'hFFFF_FFFF);
      applyStimulus(3'd3, 32'd100, 32'd7);
      waitDone(cycles);
      checkOutput("t3_divu_lo", lo, 32'd14);
      checkOutput("t3_divu_hi", hi, 32'd2);

      // Signed overflow case and a positive/negative signed divide.
      applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      waitDone(cycles);
      checkOutput("ovf_lo",  lo, 32'h8000_0000);
      checkOutput("ovf_hi",  hi, 32'd0);
      checkOutput("ovf_dbz", 32'(dbz), 32'd0);
      applyStimulus(3'd2, 32'd20, 32'hFFFF_FFFD);
      waitDone(cycles);
      checkOutput("sdiv_lo", lo, 32'hFFFF_FFFA);
      checkOutput("sdiv_hi", hi, 32'd2);

      // T4: divide by zero, flag remains set through a good DIV.
      applyStimulus(3'd3, 32'd5, 32'd0);
      waitDone(cycles);
      checkOutput("t4_busy_cycles", 32'(cycles), 32'd33);
      checkOutput("t4_lo",  lo, 32'hFFFF_FFFF);
      checkOutput("t4_hi",  hi, 32'd5);
      checkOutput("t4_dbz", 32'(dbz), 32'd1);
      applyStimulus(3'd2, 32'hFFFF_FFEC, 32'd3);
      waitDone(cycles);
      checkOutput("t4_after_lo",  lo, 32'hFFFF_FFFA);
      checkOutput("t4_after_hi",  hi, 32'hFFFF_FFFE);
      checkOutput("t4_after_dbz", 32'(dbz), 32'd1);

      // T5: MTHI and operand changes during a MULT are ignored.
      applyStimulus(3'd0, 32'd6, 32'hFFFF_FFFB);
      repeat (5) @(negedge clk);
      start = 1'b1;
      op    = 3'd4;
      opA   = 32'h0000_1234;
      opB   = 32'h0000_0055;
      @(negedge clk);
      start = 1'b0;
      opA   = 32'h0000_0077;
      waitDone(cycles);
      checkOutput("t5_hi", hi, 32'hFFFF_FFFF);
      checkOutput("t5_lo", lo, 32'hFFFF_FFE2);
      applyStimulus(3'd5, 32'h0000_ABCD, 32'd0);
      checkOutput("t5_mtlo_lo",   lo, 32'h0000_ABCD);
      checkOutput("t5_mtlo_done", 32'(done), 32'd0);
      checkOutput("t5_mtlo_busy", 32'(busy), 32'd0);
      applyStimulus(3'd4, 32'h0000_5678, 32'd0);
      checkOutput("t5_mthi_hi", hi, 32'h0000_5678);
      applyStimulus(3'd7, 32'h1111_1111, 32'd0);
      checkOutput("t5_nop_hi", hi, 32'h0000_5678);
      checkOutput("t5_nop_lo", lo, 32'h0000_ABCD);

      // T6: reset in the middle of a DIV, then a clean DIVU.
      applyStimulus(3'd2, 32'd1000, 32'd7);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("t6_busy", 32'(busy), 32'd0);
      checkOutput("t6_hi",   hi, 32'd0);
      checkOutput("t6_lo",   lo, 32'd0);
      checkOutput("t6_dbz",  32'(dbz), 32'd0);
      repeat (40) @(negedge clk);
      checkOutput("t6_no_done", 32'(done), 32'd0);
      applyStimulus(3'd3, 32'd9, 32'd3);
      waitDone(cycles);
      checkOutput("t6_divu_lo", lo, 32'd3);
      checkOutput("t6_divu_hi", hi, 32'd0);
      checkSinglePulse();

      repeat (2) @(negedge clk);
      checking = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
